// File: rtl/risc_pkg.sv
// ============================================================================
// Module : risc_pkg
// Brief  : Shared mem_op field positions, access sizes and LSU state encoding.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package risc_pkg;

    localparam int MOP_VALID = 4;
    localparam int MOP_STORE = 3;
    localparam int MOP_UNS   = 2;

    typedef enum logic [1:0] {
        SZ_B = 2'b00,
        SZ_H = 2'b01,
        SZ_W = 2'b10
    } mem_size_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RESP = 2'd2,
        ST_DONE = 2'd3
    } lsu_state_t;

    // Size 2'b11 falls through to the word case everywhere.
    function automatic logic [3:0] lsu_be(input logic [1:0] size, input logic [1:0] off);
        case (size)
            SZ_B:    lsu_be = 4'b0001 << off;
            SZ_H:    lsu_be = 4'b0011 << {off[1], 1'b0};
            default: lsu_be = 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] lsu_wdata(input logic [1:0] size, input logic [31:0] d);
        case (size)
            SZ_B:    lsu_wdata = {4{d[7:0]}};
            SZ_H:    lsu_wdata = {2{d[15:0]}};
            default: lsu_wdata = d;
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/lsu_load_ext.sv
// ============================================================================
// Module : lsu_load_ext
// Brief  : Load lane select plus sign/zero extension of the returned word.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module lsu_load_ext
    import risc_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  off,
    input  logic [1:0]  size,
    input  logic        uns,
    output logic [31:0] ext_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        case (off)
            2'd0:    w_byte = rdata[7:0];
            2'd1:    w_byte = rdata[15:8];
            2'd2:    w_byte = rdata[23:16];
            default: w_byte = rdata[31:24];
        endcase
        w_half = off[1] ? rdata[31:16] : rdata[15:0];

        case (size)
            SZ_B:    ext_data = uns ? {24'b0, w_byte} : {{24{w_byte[7]}}, w_byte};
            SZ_H:    ext_data = uns ? {16'b0, w_half} : {{16{w_half[15]}}, w_half};
            default: ext_data = rdata;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/m1_lsu.sv
// ============================================================================
// Module : m1_lsu
// Brief  : M1-stage load/store unit with req/gnt + rvalid data-memory port.
//          LSU_MISALIGN_TRAP_EN: flag misaligned H/W instead of masking addr.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module m1_lsu
    import risc_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic [4:0]      mem_op,
    input  logic [XLEN-1:0] addr,
    input  logic [XLEN-1:0] st_data,
    input  logic [4:0]      rd,
    output logic            dmem_req,
    output logic            dmem_we,
    output logic [XLEN-1:0] dmem_addr,
    output logic [3:0]      dmem_be,
    output logic [XLEN-1:0] dmem_wdata,
    input  logic            dmem_gnt,
    input  logic            dmem_rvalid,
    input  logic [XLEN-1:0] dmem_rdata,
    output logic            stall,
    output logic            ld_valid,
    output logic [XLEN-1:0] ld_data,
    output logic [4:0]      ld_rd,
    output logic            misalign
);

    lsu_state_t      r_state, w_next;
    logic            r_kill, w_kill_next;
    logic            r_store, r_uns;
    logic [1:0]      r_size, r_off;
    logic [4:0]      r_rd;
    logic [1:0]      w_size, w_off;
    logic            w_valid, w_misalign, w_accept, w_idle, w_ld_fire;
    logic [XLEN-1:0] w_ext;

    assign w_valid = mem_op[MOP_VALID];
    assign w_size  = mem_op[1:0];
    assign w_idle  = (r_state == ST_IDLE);

    // Offset is masked per size; with the trap enabled a misaligned op never issues anyway.
    always_comb begin
        case (w_size)
            SZ_B:    w_off = addr[1:0];
            SZ_H:    w_off = {addr[1], 1'b0};
            default: w_off = 2'b00;
        endcase
    end

`ifdef LSU_MISALIGN_TRAP_EN
    always_comb begin
        case (w_size)
            SZ_B:    w_misalign = 1'b0;
            SZ_H:    w_misalign = addr[0];
            default: w_misalign = (addr[1:0] != 2'b00);
        endcase
    end
`else
    assign w_misalign = 1'b0;
`endif

    assign w_accept  = w_idle & w_valid & ~w_misalign & ~flush;
    assign stall     = ~rst & (w_accept | (r_state == ST_REQ) | (r_state == ST_RESP));
    assign misalign  = ~rst & w_idle & w_valid & w_misalign;
    assign w_ld_fire = (r_state == ST_RESP) & dmem_rvalid & ~r_kill & ~flush;

    always_comb begin
        w_next      = r_state;
        w_kill_next = r_kill;
        case (r_state)
            ST_IDLE: if (w_accept) w_next = ST_REQ;
            ST_REQ: begin
                if (dmem_gnt) begin
                    if (r_store) begin
                        w_next = flush ? ST_IDLE : ST_DONE;
                    end else begin
                        w_next      = ST_RESP;
                        w_kill_next = flush;
                    end
                end else if (flush) begin
                    w_next = ST_IDLE;
                end
            end
            ST_RESP: begin
                if (flush) w_kill_next = 1'b1;
                if (dmem_rvalid) begin
                    // A killed load still has to drain its response before going idle.
                    w_next      = (r_kill | flush) ? ST_IDLE : ST_DONE;
                    w_kill_next = 1'b0;
                end
            end
            ST_DONE: w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_kill  <= 1'b0;
        end else begin
            r_state <= w_next;
            r_kill  <= w_kill_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dmem_req   <= 1'b0;
            dmem_we    <= 1'b0;
            dmem_addr  <= '0;
            dmem_be    <= 4'b0;
            dmem_wdata <= '0;
            r_store    <= 1'b0;
            r_uns      <= 1'b0;
            r_size     <= 2'b0;
            r_off      <= 2'b0;
            r_rd       <= 5'b0;
        end else begin
            dmem_req <= (w_next == ST_REQ);
            if (w_accept) begin
                dmem_we    <= mem_op[MOP_STORE];
                dmem_addr  <= {addr[XLEN-1:2], 2'b00};
                dmem_be    <= lsu_be(w_size, w_off);
                dmem_wdata <= lsu_wdata(w_size, st_data);
                r_store    <= mem_op[MOP_STORE];
                r_uns      <= mem_op[MOP_UNS];
                r_size     <= w_size;
                r_off      <= w_off;
                r_rd       <= rd;
            end
        end
    end

    lsu_load_ext u_load_ext (
        .rdata    (dmem_rdata),
        .off      (r_off),
        .size     (r_size),
        .uns      (r_uns),
        .ext_data (w_ext)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ld_valid <= 1'b0;
            ld_data  <= '0;
            ld_rd    <= 5'b0;
        end else begin
            ld_valid <= w_ld_fire;
            if (w_ld_fire) begin
                ld_data <= w_ext;
                ld_rd   <= r_rd;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_m1_lsu.sv
// ============================================================================
// Module : tb_m1_lsu
// Brief  : Directed self-checking bench for m1_lsu with a load-result scoreboard.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_m1_lsu;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic [4:0]  mem_op = 5'b0;
    logic [31:0] addr = 32'b0;
    logic [31:0] st_data = 32'b0;
    logic [4:0]  rd = 5'b0;
    logic        dmem_req, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata;
    logic [3:0]  dmem_be;
    logic        dmem_gnt = 1'b0;
    logic        dmem_rvalid = 1'b0;
    logic [31:0] dmem_rdata = 32'b0;
    logic        stall, ld_valid, misalign;
    logic [31:0] ld_data;
    logic [4:0]  ld_rd;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
    } exp_t;
    exp_t sbq[$];

    m1_lsu #(.XLEN(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .mem_op      (mem_op),
        .addr        (addr),
        .st_data     (st_data),
        .rd          (rd),
        .dmem_req    (dmem_req),
        .dmem_we     (dmem_we),
        .dmem_addr   (dmem_addr),
        .dmem_be     (dmem_be),
        .dmem_wdata  (dmem_wdata),
        .dmem_gnt    (dmem_gnt),
        .dmem_rvalid (dmem_rvalid),
        .dmem_rdata  (dmem_rdata),
        .stall       (stall),
        .ld_valid    (ld_valid),
        .ld_data     (ld_data),
        .ld_rd       (ld_rd),
        .misalign    (misalign)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Load results leave the DUT here and are matched against the scoreboard.
    always @(negedge clk) begin
        if (!rst && ld_valid) begin
            if (sbq.size() == 0) begin
                n_cmp++;
                n_err++;
                $error("FAIL sb_unexpected: observed ld_valid=1 ld_data=%h expected no load result", ld_data);
            end else begin
                exp_t e;
                e = sbq.pop_front();
                chk("sb_ld_data", ld_data, e.data);
                chk("sb_ld_rd", {27'b0, ld_rd}, {27'b0, e.rd});
            end
        end
    end

    // One full access: op presented in IDLE, optional grant delay, response for loads.
    task automatic run_op(input string tag, input logic [4:0] op, input logic [31:0] a,
                          input logic [31:0] d, input logic [4:0] r, input int gnt_dly,
                          input logic [31:0] rdata, input logic [31:0] exp_addr,
                          input logic [3:0] exp_be, input logic [31:0] exp_val);
        logic is_st;
        is_st = op[3];
        mem_op = op; addr = a; st_data = d; rd = r;
        if (!is_st) sbq.push_back('{rd: r, data: exp_val});
        #1;
        chk({tag, "_idle_stall"}, stall, 1);
        chk({tag, "_idle_req"}, dmem_req, 0);
        step();
        for (int i = 0; i < gnt_dly; i++) begin
            chk({tag, "_wait_req"}, dmem_req, 1);
            chk({tag, "_wait_addr"}, dmem_addr, exp_addr);
            chk({tag, "_wait_stall"}, stall, 1);
            step();
        end
        chk({tag, "_req"}, dmem_req, 1);
        chk({tag, "_we"}, dmem_we, is_st);
        chk({tag, "_addr"}, dmem_addr, exp_addr);
        chk({tag, "_be"}, {28'b0, dmem_be}, {28'b0, exp_be});
        if (is_st) chk({tag, "_wdata"}, dmem_wdata, exp_val);
        chk({tag, "_req_stall"}, stall, 1);
        dmem_gnt = 1'b1;
        step();
        dmem_gnt = 1'b0;
        if (!is_st) begin
            chk({tag, "_resp_stall"}, stall, 1);
            chk({tag, "_resp_req"}, dmem_req, 0);
            dmem_rvalid = 1'b1;
            dmem_rdata  = rdata;
            step();
            dmem_rvalid = 1'b0;
        end
        chk({tag, "_done_stall"}, stall, 0);
        chk({tag, "_done_ldv"}, ld_valid, !is_st);
        chk({tag, "_done_req"}, dmem_req, 0);
        mem_op = 5'b0;
        step();
        chk({tag, "_after_ldv"}, ld_valid, 0);
    endtask

    initial begin
        repeat (2) step();
        chk("rst_req", dmem_req, 0);
        chk("rst_we", dmem_we, 0);
        chk("rst_addr", dmem_addr, 0);
        chk("rst_be", {28'b0, dmem_be}, 0);
        chk("rst_wdata", dmem_wdata, 0);
        chk("rst_stall", stall, 0);
        chk("rst_ldv", ld_valid, 0);
        chk("rst_ldd", ld_data, 0);
        chk("rst_ldrd", {27'b0, ld_rd}, 0);
        chk("rst_mis", misalign, 0);
        rst = 1'b0;
        step();

        run_op("sw",  5'b11010, 32'h100, 32'hDEADBEEF, 5'd0, 0, 32'h0,        32'h100, 4'b1111, 32'hDEADBEEF);
        run_op("lb",  5'b10000, 32'h203, 32'h0,        5'd5, 0, 32'h80123456, 32'h200, 4'b1000, 32'hFFFFFF80);
        run_op("lbu", 5'b10100, 32'h203, 32'h0,        5'd6, 0, 32'h80123456, 32'h200, 4'b1000, 32'h00000080);
        run_op("sh",  5'b11001, 32'h402, 32'h1234,     5'd0, 3, 32'h0,        32'h400, 4'b1100, 32'h12341234);
        run_op("lh",  5'b10001, 32'h202, 32'h0,        5'd7, 0, 32'h8001AAAA, 32'h200, 4'b1100, 32'hFFFF8001);
        run_op("lhu", 5'b10101, 32'h000, 32'h0,        5'd8, 0, 32'h1234ABCD, 32'h000, 4'b0011, 32'h0000ABCD);
        run_op("lw",  5'b10010, 32'h104, 32'h0,        5'd3, 1, 32'hCAFEF00D, 32'h104, 4'b1111, 32'hCAFEF00D);
        run_op("sb",  5'b11000, 32'h011, 32'h000000A5, 5'd0, 0, 32'h0,        32'h010, 4'b0010, 32'hA5A5A5A5);

`ifdef LSU_MISALIGN_TRAP_EN
        mem_op = 5'b10010; addr = 32'h101; rd = 5'd9;
        #1;
        chk("mis_flag", misalign, 1);
        chk("mis_stall", stall, 0);
        step();
        chk("mis_noreq", dmem_req, 0);
        mem_op = 5'b0;
        #1;
        chk("mis_clear", misalign, 0);
        step();
`else
        run_op("lw_unal", 5'b10010, 32'h101, 32'h0, 5'd9, 0, 32'h11223344, 32'h100, 4'b1111, 32'h11223344);
        chk("nomis_flag", misalign, 0);
`endif

        // Flush while waiting for load data: response drained, no result.
        mem_op = 5'b10010; addr = 32'h300; rd = 5'd10;
        step();
        chk("fr_req", dmem_req, 1);
        dmem_gnt = 1'b1;
        step();
        dmem_gnt = 1'b0;
        flush = 1'b1; mem_op = 5'b0;
        step();
        flush = 1'b0;
        chk("fr_stall_hold", stall, 1);
        step();
        chk("fr_stall_hold2", stall, 1);
        dmem_rvalid = 1'b1; dmem_rdata = 32'h55555555;
        step();
        dmem_rvalid = 1'b0;
        chk("fr_idle_stall", stall, 0);
        chk("fr_no_ldv", ld_valid, 0);
        step();
        chk("fr_no_ldv2", ld_valid, 0);

        run_op("lbu2", 5'b10100, 32'h302, 32'h0, 5'd11, 0, 32'h00C30000, 32'h300, 4'b0100, 32'h000000C3);

        // Flush before grant drops the request.
        mem_op = 5'b10010; addr = 32'h500; rd = 5'd12;
        step();
        chk("fq_req", dmem_req, 1);
        flush = 1'b1; mem_op = 5'b0;
        step();
        flush = 1'b0;
        chk("fq_dropped", dmem_req, 0);
        chk("fq_stall", stall, 0);

        // Asynchronous reset in the middle of a load.
        mem_op = 5'b10010; addr = 32'h600; rd = 5'd13;
        step();
        dmem_gnt = 1'b1;
        step();
        dmem_gnt = 1'b0;
        chk("ar_pre_stall", stall, 1);
        rst = 1'b1;
        #2;
        chk("ar_req", dmem_req, 0);
        chk("ar_addr", dmem_addr, 0);
        chk("ar_be", {28'b0, dmem_be}, 0);
        chk("ar_stall", stall, 0);
        chk("ar_ldv", ld_valid, 0);
        chk("ar_ldd", ld_data, 0);
        chk("ar_mis", misalign, 0);
        mem_op = 5'b0;
        #1;
        rst = 1'b0;
        step();
        chk("ar_idle_stall", stall, 0);
        chk("ar_idle_req", dmem_req, 0);

        run_op("lb_post", 5'b10000, 32'h001, 32'h0, 5'd14, 0, 32'h00007F00, 32'h000, 4'b0010, 32'h0000007F);

        repeat (2) step();
        chk("sb_drain", sbq.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
